// File: rtl/clock_set_ctrl_pkg.sv
// clock_pkg: shared mode encoding, field limits and field type for the MM:SS controller.
package clock_pkg;
    typedef enum logic [1:0] {RUN = 2'd0, SET_MIN = 2'd1, SET_SEC = 2'd2} mode_t;
    localparam int MAX_SEC = 59;
    localparam int MAX_MIN = 59;
    typedef logic [5:0] time_field_t;
endpackage

// File: rtl/clock_set_ctrl_if.sv
// clock_set_ctrl_if: button pulses in, time/mode/blink/tick status out.
interface clock_set_ctrl_if;
    import clock_pkg::*;
    logic        btn_mode;
    logic        btn_inc;
    logic        btn_dec;
    time_field_t seconds;
    time_field_t minutes;
    logic [1:0]  mode;
    logic        blink;
    logic        sec_tick;
    modport master (output btn_mode, btn_inc, btn_dec, input seconds, minutes, mode, blink, sec_tick);
    modport slave  (input btn_mode, btn_inc, btn_dec, output seconds, minutes, mode, blink, sec_tick);
endinterface

// File: rtl/clock_set_ctrl_time_counter.sv
// time_counter: mod-(MAX+1) 6-bit field with inc/dec; simultaneous inc and dec cancel.
module time_counter
    import clock_pkg::*;
#(
    parameter int MAX = 59
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_inc,
    input  logic        i_dec,
    output time_field_t o_value,
    output logic        o_carry
);
    time_field_t r_value;
    logic        w_up;
    logic        w_dn;
    logic        w_at_max;
    assign w_up     = i_inc & ~i_dec;
    assign w_dn     = i_dec & ~i_inc;
    assign w_at_max = r_value == time_field_t'(MAX);
    assign o_carry  = w_up & w_at_max;
    assign o_value  = r_value;
    always_ff @(posedge clk) begin
        if (reset)     r_value <= '0;
        else if (w_up) r_value <= w_at_max ? '0 : r_value + 6'd1;
        else if (w_dn) r_value <= (r_value == '0) ? time_field_t'(MAX) : r_value - 6'd1;
    end
endmodule

// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: 1 s prescaler, RUN/SET_MIN/SET_SEC sequencing and MM:SS time registers.
module clock_set_ctrl
    import clock_pkg::*;
#(
    parameter int CLK_DIV = 100
) (
    input  logic             clk,
    input  logic             reset,
    clock_set_ctrl_if.slave  bus
);
    localparam int         DIV_W     = $clog2(CLK_DIV);
    localparam logic [1:0] S_RUN     = RUN;
    localparam logic [1:0] S_SET_MIN = SET_MIN;
    localparam logic [1:0] S_SET_SEC = SET_SEC;
    logic [DIV_W-1:0] r_div;
    logic [1:0]       r_mode;
    logic [1:0]       w_mode_nxt;
    logic             r_blink;
    logic             w_tick;
    logic             w_resync;
    logic             w_sec_carry;
    logic             w_min_carry;
    assign w_tick   = r_div == DIV_W'(CLK_DIV - 1);
    // leaving SET_SEC restarts the second so the first RUN tick is a full period away
    assign w_resync = bus.btn_mode & (r_mode == S_SET_SEC);
    always_comb begin
        w_mode_nxt = !bus.btn_mode      ? r_mode    :
                     r_mode == S_RUN     ? S_SET_MIN :
                     r_mode == S_SET_MIN ? S_SET_SEC : S_RUN;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            r_div   <= '0;
            r_mode  <= S_RUN;
            r_blink <= 1'b0;
        end else begin
            r_div   <= (w_tick | w_resync) ? '0 : r_div + DIV_W'(1);
            r_mode  <= w_mode_nxt;
            r_blink <= (w_mode_nxt == S_RUN) ? 1'b0 : r_blink ^ (w_tick & (r_mode != S_RUN));
        end
    end
    time_counter #(.MAX(MAX_SEC)) u_sec (
        .clk     (clk),
        .reset   (reset),
        .i_inc   (((r_mode == S_RUN) & w_tick) | ((r_mode == S_SET_SEC) & bus.btn_inc)),
        .i_dec   ((r_mode == S_SET_SEC) & bus.btn_dec),
        .o_value (bus.seconds),
        .o_carry (w_sec_carry)
    );
    time_counter #(.MAX(MAX_MIN)) u_min (
        .clk     (clk),
        .reset   (reset),
        .i_inc   (((r_mode == S_RUN) & w_sec_carry) | ((r_mode == S_SET_MIN) & bus.btn_inc)),
        .i_dec   ((r_mode == S_SET_MIN) & bus.btn_dec),
        .o_value (bus.minutes),
        .o_carry (w_min_carry)
    );
    assign bus.mode     = r_mode;
    assign bus.blink    = r_blink;
    assign bus.sec_tick = w_tick;
    logic w_unused;
    assign w_unused = w_min_carry;
endmodule

// File: tb/tb_clock_set_ctrl.sv
// tb_clock_set_ctrl: scoreboard bench with an integer reference model of the clock controller.
module tb_clock_set_ctrl;
    localparam int CLK_DIV = 4;
    typedef struct {int s; int m; int md; int b;} exp_t;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int n_checks = 0;
    int n_fail = 0;
    int m_s = 0, m_m = 0, m_md = 0, m_b = 0, m_div = 0;
    exp_t sb[$];
    clock_set_ctrl_if bus();
    clock_set_ctrl #(.CLK_DIV(CLK_DIV)) dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask
    task automatic step(input logic r, input logic md, input logic inc, input logic dec);
        exp_t e;
        int d, nmd;
        bit tk;
        reset = r;
        bus.btn_mode = md;
        bus.btn_inc = inc;
        bus.btn_dec = dec;
        tk = (m_div == CLK_DIV - 1);
        if (!r) chk("sec_tick", int'(bus.sec_tick), int'(tk));
        if (r) begin
            m_s = 0; m_m = 0; m_md = 0; m_b = 0; m_div = 0;
        end else begin
            d = (inc && !dec) ? 1 : (dec && !inc) ? 59 : 0;
            nmd = md ? (m_md + 1) % 3 : m_md;
            case (m_md)
                0: if (tk) begin
                       if (m_s == 59) m_m = (m_m + 1) % 60;
                       m_s = (m_s + 1) % 60;
                   end
                1: m_m = (m_m + d) % 60;
                default: m_s = (m_s + d) % 60;
            endcase
            m_b = (nmd == 0) ? 0 : m_b ^ int'(tk && m_md != 0);
            m_div = ((md && m_md == 2) || tk) ? 0 : m_div + 1;
            m_md = nmd;
        end
        sb.push_back('{m_s, m_m, m_md, m_b});
        @(posedge clk);
        #1;
        bus.btn_mode = 1'b0;
        bus.btn_inc = 1'b0;
        bus.btn_dec = 1'b0;
        if (sb.size() == 0) begin
            chk("sb_empty", 0, 1);
        end else begin
            e = sb.pop_front();
            chk("seconds", int'(bus.seconds), e.s);
            chk("minutes", int'(bus.minutes), e.m);
            chk("mode", int'(bus.mode), e.md);
            chk("blink", int'(bus.blink), e.b);
        end
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end
    initial begin
        int b0, toggles, prev;
        bus.btn_mode = 1'b0;
        bus.btn_inc = 1'b0;
        bus.btn_dec = 1'b0;
        // 1: reset then free run
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        chk("rst_sec", int'(bus.seconds), 0);
        chk("rst_mode", int'(bus.mode), 0);
        for (int c = 0; c < 12; c++) begin
            chk("t1_tick", int'(bus.sec_tick), int'(c % 4 == 3));
            step(0, 0, 0, 0);
            if (c % 4 == 3) chk("t1_sec", int'(bus.seconds), c / 4 + 1);
        end
        chk("t1_min", int'(bus.minutes), 0);
        chk("t1_mode", int'(bus.mode), 0);
        // 2: preload 00:59, run into carry, then 59:59 wrap
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        for (int i = 0; i < 59; i++) step(0, 0, 1, 0);
        chk("t2_preload", int'(bus.seconds), 59);
        step(0, 1, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
        chk("t2_sec", int'(bus.seconds), 0);
        chk("t2_min", int'(bus.minutes), 1);
        step(0, 1, 0, 0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        step(0, 1, 0, 0);
        step(0, 0, 0, 1);
        step(0, 1, 0, 0);
        chk("t2_5959_m", int'(bus.minutes), 59);
        chk("t2_5959_s", int'(bus.seconds), 59);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
        chk("t2_wrap_m", int'(bus.minutes), 0);
        chk("t2_wrap_s", int'(bus.seconds), 0);
        // 3: SET_MIN borrow and frozen time with blinking
        step(0, 1, 0, 0);
        chk("t3_blink0", int'(bus.blink), 0);
        step(0, 0, 0, 1);
        chk("t3_min", int'(bus.minutes), 59);
        chk("t3_sec", int'(bus.seconds), 0);
        b0 = int'(bus.blink);
        prev = b0;
        toggles = 0;
        for (int i = 0; i < 40; i++) begin
            step(0, 0, 0, 0);
            if (int'(bus.blink) != prev) toggles++;
            prev = int'(bus.blink);
        end
        chk("t3_toggles", toggles, 10);
        chk("t3_blink_end", int'(bus.blink), b0);
        chk("t3_frozen_m", int'(bus.minutes), 59);
        chk("t3_frozen_s", int'(bus.seconds), 0);
        // 4: SET_SEC wrap without carry, inc+dec cancel
        step(0, 1, 0, 0);
        step(0, 0, 0, 1);
        chk("t4_s59", int'(bus.seconds), 59);
        step(0, 0, 1, 0);
        chk("t4_wrap_s", int'(bus.seconds), 0);
        chk("t4_wrap_m", int'(bus.minutes), 59);
        step(0, 0, 1, 1);
        chk("t4_both_s", int'(bus.seconds), 0);
        chk("t4_both_m", int'(bus.minutes), 59);
        // 5: mode with inc in SET_MIN, then resync on return to RUN
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        while (m_m != 5) step(0, 0, 1, 0);
        step(0, 1, 1, 0);
        chk("t5_min", int'(bus.minutes), 6);
        chk("t5_mode", int'(bus.mode), 2);
        step(0, 1, 0, 0);
        chk("t5_run", int'(bus.mode), 0);
        chk("t5_blink", int'(bus.blink), 0);
        for (int k = 1; k <= 4; k++) begin
            chk("t5_tick", int'(bus.sec_tick), int'(k == 4));
            step(0, 0, 0, 0);
        end
        // 6: reset in the middle of SET_SEC
        step(0, 1, 0, 0);
        while (m_m != 12) step(0, 0, 1, 0);
        step(0, 1, 0, 0);
        while (m_s != 34) step(0, 0, 1, 0);
        while (m_div != 2) step(0, 0, 0, 0);
        chk("t6_pre_m", int'(bus.minutes), 12);
        chk("t6_pre_s", int'(bus.seconds), 34);
        chk("t6_pre_mode", int'(bus.mode), 2);
        step(1, 0, 0, 0);
        chk("t6_m", int'(bus.minutes), 0);
        chk("t6_s", int'(bus.seconds), 0);
        chk("t6_mode", int'(bus.mode), 0);
        chk("t6_blink", int'(bus.blink), 0);
        for (int c = 0; c < 4; c++) begin
            chk("t6_tick", int'(bus.sec_tick), int'(c == 3));
            step(0, 0, 0, 0);
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/clock_set_ctrl.md
Name: clock_set_ctrl

Overview:
- Timekeeping controller for the seconds/minutes digital clock.
- Generates the 1 s count enable from the system clock with a prescaler.
- Sequences run and set modes from two debounced push-button pulses, and drives the MM:SS time registers.
- Sits between the board button debouncers and the display driver, and replaces free-running per-clock counting with tick-gated counting.

Parameters:
CLK_DIV, 100, system clock cycles per 1 s tick; must be >= 2. Board build overrides this to the real clock frequency; sim uses a small value.
DIV_W, $clog2(CLK_DIV), prescaler counter width (derived, not overridden).

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high; clears all state
btn_mode  input  1  single-cycle pulse, already debounced: advance mode
btn_inc  input  1  single-cycle pulse: increment selected field
btn_dec  input  1  single-cycle pulse: decrement selected field
seconds  output  6  current seconds, 0..59
minutes  output  6  current minutes, 0..59
mode  output  2  0=RUN, 1=SET_MIN, 2=SET_SEC (value 3 never driven)
blink  output  1  display blink phase for the field being set
sec_tick  output  1  one-cycle pulse per prescaler wrap

Behaviour:
- Reset (sync, active-high, overrides all inputs): seconds=0, minutes=0, mode=RUN, blink=0, prescaler=0, sec_tick=0.
- Prescaler div_cnt:
  - counts 0..CLK_DIV-1, then wraps to 0; runs in all modes.
  - sec_tick is decoded combinationally from the register: high exactly while div_cnt==CLK_DIV-1.
  - first sec_tick after reset is in cycle CLK_DIV-1 (cycle 0 = first cycle after reset release).
- FSM states RUN, SET_MIN, SET_SEC:
  - btn_mode moves RUN->SET_MIN->SET_SEC->RUN.
  - btn_mode ignored in no state.
  - on the SET_SEC->RUN transition, div_cnt is forced to 0, so the first tick comes a full CLK_DIV cycles later.
- RUN:
  - on sec_tick, seconds+1; seconds 59 -> 0 with carry minutes+1; minutes 59 -> 0 (59:59 -> 00:00).
  - btn_inc/btn_dec ignored.
- SET_MIN:
  - ticks do not change time.
  - btn_inc: minutes+1, 59->0. btn_dec: minutes-1, 0->59.
  - seconds untouched; no carry or borrow.
- SET_SEC:
  - same as SET_MIN, applied to seconds.
  - no carry/borrow into minutes.
- Simultaneous events:
  - btn_inc & btn_dec in the same cycle: no change.
  - btn_mode with btn_inc/btn_dec: the edit applies to the field of the current (pre-transition) state; the mode changes on the same edge.
  - sec_tick with btn_mode in RUN: the tick count is applied, then the mode changes.
- blink:
  - toggles on every sec_tick while mode != RUN.
  - forced 0 on entering RUN and held 0 in RUN.
  - entering SET_MIN from RUN starts with blink=0.
- Latency: seconds, minutes, mode and blink are registered and update on the clock edge ending the cycle in which the triggering event (tick or button) is high. One-cycle latency; no combinational input-to-output path except sec_tick from the register.
- Width rules:
  - arithmetic is 6-bit compare-then-load; never rely on modulo-64 wrap.
  - values 60..63 are unreachable and need no handling.

Decomposition:
- Shared package clock_pkg holds:
  - typedef enum logic [1:0] mode_t {RUN, SET_MIN, SET_SEC}
  - localparam MAX_SEC = 59 and MAX_MIN = 59
  - typedef logic [5:0] time_field_t
- One sub-module, time_counter:
  - 6-bit mod-60 field with inc, dec and carry_out (carry_out high when inc at 59).
  - instantiated twice; the RUN carry from seconds is routed to the minutes inc.
- Prescaler and FSM stay in the top.

Test Plan:
1. CLK_DIV=4, reset for 2 cycles then release -> sec_tick in cycles 3, 7, 11; seconds reads 1, 2, 3 after each tick edge; minutes=0; mode=0.
2. Preload to 00:59 via SET_SEC (inc x59), then return to RUN -> after 4 cycles seconds=0, minutes=1; from 59:59, one tick -> 00:00.
3. btn_mode once, then btn_dec at minutes=0 -> minutes=59, seconds unchanged. 10 ticks in SET_MIN -> time frozen, blink toggles 10 times and ends at 0.
4. In SET_SEC at seconds=59, btn_inc -> seconds=0 and minutes unchanged. btn_inc and btn_dec in the same cycle -> no change.
5. btn_mode and btn_inc in the same cycle while in SET_MIN at minutes=5 -> minutes=6, mode=SET_SEC. Then btn_mode -> mode=RUN, blink=0, next sec_tick exactly 4 cycles later.
6. Assert reset mid-SET_SEC with time 12:34 and div_cnt=2 -> next cycle 00:00, mode=RUN, blink=0, sec_tick 3 cycles after release.
